// File: rtl/data_sram_resp.sv
// Load/store front end for the data SRAM: a small committed-store buffer that drains
// into idle memory cycles, with per-byte store-to-load forwarding on loads.
module data_sram_resp #(
  parameter int SB_DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic        st_valid,
  input  logic [3:0]  st_sel,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_wdata,
  output logic        st_ready,
  output logic        mem_en,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        sb_empty
);

  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = SB_DEPTH[PTR_W:0];

  typedef logic [PTR_W-1:0] ptr_t;

  logic [29:0] sb_addr [SB_DEPTH];
  logic [3:0]  sb_sel  [SB_DEPTH];
  logic [31:0] sb_data [SB_DEPTH];
  logic [SB_DEPTH-1:0] sb_valid;

  ptr_t         wr_ptr;
  ptr_t         rd_ptr;
  logic [PTR_W:0] count;

  logic        enq;
  logic        load;
  logic        drain;
  logic [3:0]  fwd_mask_d;
  logic [31:0] fwd_data_d;
  logic [3:0]  fwd_mask;
  logic [31:0] fwd_data;
  ptr_t        idx;

  logic unused_inputs;
  assign unused_inputs = ^{data_sram_wen, data_sram_wdata, data_sram_addr[1:0], st_addr[1:0]};

  // st_ready looks only at the registered count, so a full buffer stays closed
  // even in a cycle where it is draining.
  assign st_ready = (count != FULL_COUNT);
  assign sb_empty = (count == '0);
  assign enq      = st_valid && st_ready;
  assign load     = data_sram_en && resetn;
  assign drain    = resetn && !data_sram_en && (count != '0);

  // Oldest-to-newest walk so later matches overwrite earlier ones per lane; the
  // store accepted this cycle is applied last as the newest.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    fwd_mask_d = '0;
    fwd_data_d = '0;
    idx        = rd_ptr;
    for (int i = 0; i < SB_DEPTH; i++) begin
      idx = rd_ptr + ptr_t'(i);
      if (sb_valid[idx] && (sb_addr[idx] == data_sram_addr[31:2])) begin
        for (int b = 0; b < 4; b++) begin
          if (sb_sel[idx][b]) begin
            fwd_mask_d[b]       = 1'b1;
            fwd_data_d[8*b +: 8] = sb_data[idx][8*b +: 8];
          end
        end
      end
    end
    if (enq && (st_addr[31:2] == data_sram_addr[31:2])) begin
      for (int b = 0; b < 4; b++) begin
        if (st_sel[b]) begin
          fwd_mask_d[b]       = 1'b1;
          fwd_data_d[8*b +: 8] = st_wdata[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_wen   = 4'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (load) begin
      mem_en   = 1'b1;
      mem_addr = {data_sram_addr[31:2], 2'b00};
    end else if (drain) begin
      mem_en    = 1'b1;
      mem_wen   = sb_sel[rd_ptr];
      mem_addr  = {sb_addr[rd_ptr], 2'b00};
      mem_wdata = sb_data[rd_ptr];
    end
  end

  always_comb begin
    data_sram_rdata = mem_rdata;
    for (int b = 0; b < 4; b++) begin
      if (fwd_mask[b]) data_sram_rdata[8*b +: 8] = fwd_data[8*b +: 8];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      sb_valid <= '0;
      fwd_mask <= '0;
      fwd_data <= '0;
    end else begin
      if (enq) begin
        sb_valid[wr_ptr] <= 1'b1;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (drain) begin
        sb_valid[rd_ptr] <= 1'b0;
        rd_ptr           <= rd_ptr + 1'b1;
      end
      count    <= count + {{PTR_W{1'b0}}, enq} - {{PTR_W{1'b0}}, drain};
      fwd_mask <= load ? fwd_mask_d : 4'b0;
      fwd_data <= load ? fwd_data_d : '0;
    end
  end

  // NOTE: entry payload is left unreset; sb_valid alone decides whether an entry exists.
  always_ff @(posedge clk) begin
    if (enq) begin
      sb_addr[wr_ptr] <= st_addr[31:2];
      sb_sel[wr_ptr]  <= st_sel;
      sb_data[wr_ptr] <= st_wdata;
    end
  end

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed bench for data_sram_resp: expected memory writes and load words are queued
// as stimulus is driven and compared when the DUT produces them.
module tb_data_sram_resp;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        st_valid;
  logic [3:0]  st_sel;
  logic [31:0] st_addr;
  logic [31:0] st_wdata;
  logic        st_ready;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        sb_empty;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wen;
    logic [31:0] data;
  } wr_t;

  wr_t         wq[$];
  logic [31:0] lq[$];
  logic        rsp_due = 1'b0;
  int          tests = 0;
  int          fails = 0;

  data_sram_resp #(.SB_DEPTH(4)) dut (
    .clk(clk), .resetn(resetn),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata),
    .st_valid(st_valid), .st_sel(st_sel), .st_addr(st_addr), .st_wdata(st_wdata),
    .st_ready(st_ready),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .sb_empty(sb_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive_store(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    st_valid = 1'b1;
    st_addr  = a;
    st_sel   = s;
    st_wdata = d;
    wq.push_back('{a & 32'hFFFF_FFFC, s, d});
  endtask

  task automatic drive_load(input logic [31:0] a, input logic [31:0] exp);
    data_sram_en   = 1'b1;
    data_sram_addr = a;
    lq.push_back(exp);
  endtask

  always @(posedge clk) rsp_due <= data_sram_en && resetn;

  // Memory-side and load-response scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (resetn) begin
      if (mem_en && (mem_wen != 4'b0)) begin
        if (wq.size() == 0) begin
          check("unexpected_write", {28'b0, mem_wen}, 32'h0);
        end else begin
          wr_t e;
          e = wq.pop_front();
          check("wr_addr", mem_addr, e.addr);
          check("wr_wen", {28'b0, mem_wen}, {28'b0, e.wen});
          check("wr_data", mem_wdata, e.data);
        end
      end
      if (rsp_due && (lq.size() != 0)) check("load_rdata", data_sram_rdata, lq.pop_front());
    end
  end

  initial begin
    data_sram_en = 1'b0; data_sram_wen = 4'hF; data_sram_addr = '0; data_sram_wdata = 32'hDEAD_BEEF;
    st_valid = 1'b0; st_sel = '0; st_addr = '0; st_wdata = '0;
    mem_rdata = 32'hCAFE_F00D;

    #3;
    check("rst_st_ready", st_ready, 1);
    check("rst_sb_empty", sb_empty, 1);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_wen", {28'b0, mem_wen}, 0);
    check("rst_rdata", data_sram_rdata, 32'hCAFE_F00D);
    repeat (2) tick();
    resetn = 1'b1;

    // Single full-word store drains the cycle after it is accepted.
    drive_store(32'h100, 4'hF, 32'hAABB_CCDD);
    settle();
    check("no_bypass", mem_en, 0);
    tick();
    st_valid = 1'b0;
    settle();
    check("drain_en", mem_en, 1);
    check("drain_addr", mem_addr, 32'h100);
    check("drain_wen", {28'b0, mem_wen}, 32'hF);
    tick();
    settle();
    check("t1_empty", sb_empty, 1);
    check("t1_idle", mem_en, 0);

    // Two byte stores to one word held behind loads; newest byte wins.
    mem_rdata = 32'hFFFF_FFFF;
    drive_load(32'h400, 32'hFFFF_FFFF); drive_store(32'h200, 4'b0001, 32'h11); tick();
    drive_load(32'h400, 32'hFFFF_FFFF); drive_store(32'h200, 4'b0001, 32'h22); tick();
    drive_load(32'h202, 32'hFFFF_FF22);
    st_valid = 1'b0;
    settle();
    check("load_en", mem_en, 1);
    check("load_wen", {28'b0, mem_wen}, 0);
    check("load_addr_align", mem_addr, 32'h200);
    check("t2_not_empty", sb_empty, 0);
    tick();
    data_sram_en = 1'b0;
    repeat (2) tick();
    settle();
    check("t2_empty", sb_empty, 1);

    // Fill the buffer under loads, hold a fifth store, then release one slot.
    mem_rdata = 32'h0;
    for (int k = 0; k < 4; k++) begin
      drive_load(32'h800, 32'h0);
      drive_store(32'h500 + 32'(4 * k), 4'hF, 32'h0101_0101 * 32'(k + 1));
      settle();
      check("fill_ready", st_ready, 1);
      tick();
    end
    drive_load(32'h800, 32'h0);
    st_valid = 1'b1; st_addr = 32'h510; st_sel = 4'hF; st_wdata = 32'h5555_5555;
    settle();
    check("full_ready", st_ready, 0);
    tick();
    data_sram_en = 1'b0;
    settle();
    check("full_during_drain", st_ready, 0);
    check("drain_head_addr", mem_addr, 32'h500);
    tick();
    settle();
    check("ready_after_drain", st_ready, 1);
    wq.push_back('{32'h510, 4'hF, 32'h5555_5555});
    tick();
    st_valid = 1'b0;
    repeat (4) tick();
    settle();
    check("t3_empty", sb_empty, 1);

    // Load and store to the same word in one cycle forward the new bytes.
    drive_load(32'h302, 32'h1234_0000);
    drive_store(32'h300, 4'b1100, 32'h1234_0000);
    tick();
    data_sram_en = 1'b0;
    st_valid = 1'b0;
    settle();
    check("t4_drain_wen", {28'b0, mem_wen}, 32'hC);
    check("t4_drain_addr", mem_addr, 32'h300);
    tick();
    mem_rdata = 32'h7654_3210;
    settle();
    check("no_fwd_after_idle", data_sram_rdata, 32'h7654_3210);
    check("t4_empty", sb_empty, 1);

    // Reset mid-operation discards buffered stores.
    mem_rdata = 32'h0;
    for (int k = 0; k < 3; k++) begin
      drive_load(32'h900, 32'h0);
      drive_store(32'h600 + 32'(4 * k), 4'hF, 32'(k + 1));
      tick();
    end
    data_sram_en = 1'b1;
    st_valid = 1'b0;
    settle();
    check("pre_rst_not_empty", sb_empty, 0);
    resetn = 1'b0;
    data_sram_en = 1'b0;
    mem_rdata = 32'h5A5A_5A5A;
    #1;
    check("mid_rst_empty", sb_empty, 1);
    check("mid_rst_ready", st_ready, 1);
    check("mid_rst_mem_en", mem_en, 0);
    check("mid_rst_mem_wen", {28'b0, mem_wen}, 0);
    check("mid_rst_rdata", data_sram_rdata, 32'h5A5A_5A5A);
    wq.delete();
    lq.delete();
    repeat (2) tick();
    resetn = 1'b1;
    settle();
    check("post_rst_mem_en", mem_en, 0);
    check("post_rst_empty", sb_empty, 1);
    repeat (4) tick();
    check("post_rst_still_empty", sb_empty, 1);

    check("wq_drained", wq.size(), 0);
    check("lq_drained", lq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_sram_resp.md
DATA_SRAM_RESP -- requirements
Module: data_sram_resp

Interface
REQ-001 SHALL have parameter SB_DEPTH, default 4, meaning number of store-buffer entries (power of two, minimum 2).
REQ-002 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-003 SHALL have port resetn, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port data_sram_en, input, 1: load request valid from AGU.
REQ-005 SHALL have port data_sram_wen, input, 4: write enable from AGU; ignored, because stores enter only via st_*.
REQ-006 SHALL have port data_sram_addr, input, 32: load byte address.
REQ-007 SHALL have port data_sram_wdata, input, 32: ignored.
REQ-008 SHALL have port data_sram_rdata, output, 32: load word, valid the cycle after data_sram_en.
REQ-009 SHALL have port st_valid, input, 1: committed store offered.
REQ-010 SHALL have port st_sel, input, 4: store byte lanes.
REQ-011 SHALL have port st_addr, input, 32: store byte address.
REQ-012 SHALL have port st_wdata, input, 32: lane-replicated store data.
REQ-013 SHALL have port st_ready, output, 1: buffer can accept a store.
REQ-014 SHALL have port mem_en, output, 1: backing-SRAM access.
REQ-015 SHALL have port mem_wen, output, 4: backing-SRAM byte write enables.
REQ-016 SHALL have port mem_addr, output, 32: word-aligned address, bits[1:0] = 0.
REQ-017 SHALL have port mem_wdata, output, 32: write data.
REQ-018 SHALL have port mem_rdata, input, 32: synchronous read data, one-cycle latency.
REQ-019 SHALL have port sb_empty, output, 1: store buffer holds no entries.

Function
REQ-020 SHALL hold stores in a SB_DEPTH-entry FIFO (addr[31:2], sel, wdata) with wrap-around read/write pointers and a count.
REQ-021 SHALL enqueue a store when st_valid && st_ready are both high at the clock edge.
REQ-022 SHALL drive st_ready = (count != SB_DEPTH), computed from registered count only.
REQ-023 SHALL leave st_ready low when full, even if a drain occurs in the same cycle.
REQ-024 SHALL give a load priority on the memory port: when data_sram_en = 1, drive mem_en = 1, mem_wen = 0, mem_addr = {data_sram_addr[31:2], 2'b00}.
REQ-025 SHALL drain the head entry when data_sram_en = 0 and count > 0: mem_en = 1, mem_wen = head sel, mem_addr = head word address, mem_wdata = head data.
REQ-026 SHALL pop the drained entry in the drain cycle, because each write completes in one cycle.
REQ-027 SHALL drive mem_en = 0, mem_wen = 0 and mem_addr/mem_wdata = 0 when there is neither a load nor a drain.
REQ-028 SHALL NOT bypass an enqueue to memory when the buffer is empty; the earliest drain is the cycle after the enqueue.
REQ-029 SHALL compute forwarding for a load in request cycle N over resident entries whose word address matches, plus a same-cycle accepted st_* store to the same word, treated as newest.
REQ-030 SHALL resolve forwarding per byte lane, with the newest matching store winning.
REQ-031 SHALL register the forwarded byte mask and byte data at the end of cycle N.
REQ-032 SHALL drive, in cycle N+1, data_sram_rdata lane i = forwarded byte if mask[i], else mem_rdata lane i.
REQ-033 SHALL force the registered mask to 0 in the cycle after any non-load cycle, so that data_sram_rdata = mem_rdata.
REQ-034 SHALL allow a store enqueue during a load cycle; the enqueued entry cannot drain in that cycle.
REQ-035 SHALL support back-to-back loads; each response corresponds to the immediately preceding request cycle.
REQ-036 SHALL set sb_empty = (count == 0).

Reset
REQ-037 SHALL, on resetn low, immediately clear count, pointers, entry valids, forward mask and forward data.
REQ-038 SHALL, during reset, drive st_ready = 1, sb_empty = 1, mem_en = 0, mem_wen = 0, and data_sram_rdata = mem_rdata.
REQ-039 SHALL discard buffered stores and any in-flight forward when reset is asserted mid-operation; the first cycle after release behaves as empty.

Verification
REQ-040 SHALL pass: store sel=4'b1111 addr 0x100 data 0xAABBCCDD, no loads -> next cycle mem_en=1, mem_wen=1111, mem_addr=0x100, then sb_empty=1.
REQ-041 SHALL pass: stores sel 0001 data 0x11 then sel 0001 data 0x22 to 0x200, held by continuous loads; load 0x200 with mem_rdata 0xFFFFFFFF -> rdata 0xFFFFFF22.
REQ-042 SHALL pass: 4 stores during continuous loads -> st_ready=0 after the 4th; 5th is held; first idle cycle drains entry 0; st_ready=1 the next cycle.
REQ-043 SHALL pass: load and store sel 1100 data 0x12340000 to 0x300 in the same cycle, mem_rdata 0 -> rdata 0x12340000; drain follows.
REQ-044 SHALL pass: 3 entries buffered, resetn pulsed low mid-cycle -> sb_empty=1 and st_ready=1 immediately; no mem write after release.
